hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the redirect pipeline. It replaces fixed opcode-decoded comparisons with a shift-register scoreboard of in-flight destination registers, one entry per post-ID stage.
- Generates the load-use/late-result stall and per-source forwarding selects for the ID-stage instruction.
- Adds a multi-cycle MDU busy counter for structural hazards and a saturating stall performance counter.

Parameters:
- REG_W, 5, register address width.
- DEPTH, 3, number of tracked post-ID stages (1=EX, 2=MEM, 3=WB); legal range 2..7.
- LOAD_STAGE, 2, first stage index at which a load result can be forwarded; legal range 1..DEPTH.
- MDU_LAT, 4, cycles the MDU stays busy after issue; legal range ≥1.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1_en  in  1  instruction reads source 1.
- id_src1  in  REG_W  source 1 register.
- id_src2_en  in  1  instruction reads source 2.
- id_src2  in  REG_W  source 2 register.
- id_dst_en  in  1  instruction writes a register.
- id_dst  in  REG_W  destination register.
- id_is_load  in  1  result available at LOAD_STAGE; otherwise at stage 1.
- id_is_mdu  in  1  instruction issues to the MDU.
- id_uses_hilo  in  1  instruction reads MDU result (mfhi/mflo class).
- flush  in  1  squash the ID instruction (branch redirect).
- stall  out  1  hold PC/IF/ID and insert a bubble into EX.
- fwd_sel1  out  3  source 1 operand select: 0 = register file, k = stage k.
- fwd_sel2  out  3  source 2 operand select, same encoding.
- mdu_busy  out  1  MDU counter non-zero.
- stall_count  out  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid; MDU counter 0; stall_count 0.
  - Hence stall=0, fwd_sel1=fwd_sel2=0, mdu_busy=0 while held in reset and immediately after release.
- Entry contents: valid, dst, avail (1 for non-load, LOAD_STAGE for load).
  - Entries with dst_en=0 or dst=0 are stored invalid; register 0 never matches.
- Shift, every clock:
  - Entry k moves to k+1; entry DEPTH is dropped.
  - Stage 1 loads the ID instruction's tag when id_valid & ~stall & ~flush; otherwise stage 1 loads a bubble (invalid).
- Source match (combinational from current state), per enabled source s with s≠0:
  - Find the smallest k with entry k valid and dst==s (youngest producer wins).
  - If k ≥ avail: fwd_sel = k.
  - If k < avail: not ready; raise data stall, fwd_sel = 0.
  - If no match, or the source is disabled: fwd_sel = 0.
- Structural stall:
  - Asserted when id_valid & (id_is_mdu | id_uses_hilo) & mdu_busy.
- stall = id_valid & ~flush & (data stall | structural stall).
  - flush has priority: stall=0 during flush and a bubble enters stage 1.
- MDU counter:
  - Loads MDU_LAT when id_valid & id_is_mdu & ~stall & ~flush.
  - Otherwise decrements if non-zero.
  - mdu_busy = (counter ≠ 0). A new MDU op on the cycle the counter reads 1 still stalls.
- stall_count increments on each cycle with stall=1 and saturates at all-ones; it is never cleared except by reset.
- Stall timing: a load at stage 1 consumed by ID gives exactly LOAD_STAGE−1 stall cycles. With LOAD_STAGE=2 that is 1 cycle, after which the select is 2.
- Reset asserted mid-operation discards all in-flight entries and the MDU count immediately.
- fwd_sel is meaningful only when stall=0.

Test Plan:
- Reset with rst_n=0 mid-stream, MDU counter at 3 → next cycle stall=0, mdu_busy=0, fwd_sel*=0, stall_count=0.
- ALU-to-ALU: issue add r5 then sub r6,r5,r5 → cycle 2: stall=0, fwd_sel1=fwd_sel2=1. A consumer two instructions later gets fwd_sel=2, three later gets 3, four later gets 0.
- Load-use (LOAD_STAGE=2): lw r8 then add r9,r8,r1 → one cycle stall=1, fwd_sel1=0. Next cycle stall=0, fwd_sel1=2, stall_count=1.
- Youngest wins: add r3; add r3; or r4,r3,r0 → fwd_sel1=1, not 2. A source of r0 always gives fwd_sel=0 even if r0 is in flight.
- MDU: mult at cycle 0, mflo at cycle 1 → stall on cycles 1–4 (MDU_LAT=4), mflo issues cycle 5. A second mult at cycle 4 also stalls.
- Flush during a load-use stall → stall=0 that cycle, bubble enters stage 1, stall_count unchanged. Then saturate stall_count (CNT_W=4): 20 stall cycles → reads 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard detection and operand forwarding for the ID stage.
// A shift-register scoreboard follows the destination register of every
// in-flight instruction through the post-ID stages (1=EX .. DEPTH), together
// with the first stage at which its result can be forwarded. ID sources are
// matched against it to produce forwarding selects and a data stall. A
// countdown models the multi-cycle MDU for structural stalls, and a saturating
// counter tallies stall cycles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_src1_en/id_src1         source 1 read enable / register
//   id_src2_en/id_src2         source 2 read enable / register
//   id_dst_en/id_dst           destination write enable / register
//   id_is_load                 result ready at LOAD_STAGE instead of stage 1
//   id_is_mdu                  instruction issues to the MDU
//   id_uses_hilo               instruction reads the MDU result
//   flush                      squash the ID instruction
//   stall                      hold PC/IF/ID, bubble into EX
//   fwd_sel1/fwd_sel2          0 = register file, k = forward from stage k
//   mdu_busy                   MDU countdown non-zero
//   stall_count                saturating count of stall cycles
module hazard_scoreboard #(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int MDU_LAT    = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_src1_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src2_en,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_dst_en,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_is_load,
    input  logic             id_is_mdu,
    input  logic             id_uses_hilo,
    input  logic             flush,
    output logic             stall,
    output logic [2:0]       fwd_sel1,
    output logic [2:0]       fwd_sel2,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MW = (MDU_LAT < 1) ? 1 : $clog2(MDU_LAT + 1);

    // Scoreboard entries, index 1 = EX stage.
    logic [DEPTH:1]            e_vld;
    logic [DEPTH:1][REG_W-1:0] e_dst;
    logic [DEPTH:1][2:0]       e_avail;

    logic [MW-1:0] mdu_cnt;
    logic          hz1, hz2, data_stall, struct_stall, issue;

    // Source match. Scanning from the oldest stage down to stage 1 and letting
    // each hit overwrite the previous one leaves the youngest producer in place.
    always_comb begin
        fwd_sel1 = 3'd0;
        fwd_sel2 = 3'd0;
        hz1      = 1'b0;
        hz2      = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_src1_en && (id_src1 != '0) && e_vld[k] && (e_dst[k] == id_src1)) begin
                hz1      = (k < int'(e_avail[k]));
                fwd_sel1 = hz1 ? 3'd0 : 3'(k);
            end
            if (id_src2_en && (id_src2 != '0) && e_vld[k] && (e_dst[k] == id_src2)) begin
                hz2      = (k < int'(e_avail[k]));
                fwd_sel2 = hz2 ? 3'd0 : 3'(k);
            end
        end
    end

    assign mdu_busy     = (mdu_cnt != '0);
    assign data_stall   = hz1 | hz2;
    assign struct_stall = (id_is_mdu | id_uses_hilo) & mdu_busy;
    // flush wins: a squashed instruction never stalls, it just becomes a bubble.
    assign stall        = id_valid & ~flush & (data_stall | struct_stall);
    assign issue        = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld   <= '0;
            e_dst   <= '0;
            e_avail <= '0;
        end else begin
            for (int k = 2; k <= DEPTH; k++) begin
                e_vld[k]   <= e_vld[k-1];
                e_dst[k]   <= e_dst[k-1];
                e_avail[k] <= e_avail[k-1];
            end
            // r0 writes are tracked as bubbles so they can never match.
            e_vld[1]   <= issue & id_dst_en & (id_dst != '0);
            e_dst[1]   <= id_dst;
            e_avail[1] <= id_is_load ? 3'(LOAD_STAGE) : 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdu_cnt <= '0;
        else if (issue && id_is_mdu)
            mdu_cnt <= MW'(MDU_LAT);
        else if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - MW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, LOAD_STAGE=2, MDU_LAT=4,
// CNT_W=4 so that stall counter saturation is reachable quickly).
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_src1_en, id_src2_en, id_dst_en;
    logic [4:0] id_src1, id_src2, id_dst;
    logic       id_is_load, id_is_mdu, id_uses_hilo, flush;
    logic       stall, mdu_busy;
    logic [2:0] fwd_sel1, fwd_sel2;
    logic [3:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .REG_W(5), .DEPTH(3), .LOAD_STAGE(2), .MDU_LAT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid),
        .id_src1_en(id_src1_en), .id_src1(id_src1),
        .id_src2_en(id_src2_en), .id_src2(id_src2),
        .id_dst_en(id_dst_en), .id_dst(id_dst),
        .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
        .id_uses_hilo(id_uses_hilo), .flush(flush),
        .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Instruction drive: s1/s2/d are registers, 0 with enable cleared when unused.
    task automatic drive(input logic v, input logic s1e, input logic [4:0] s1,
                         input logic s2e, input logic [4:0] s2,
                         input logic de, input logic [4:0] d,
                         input logic ld, input logic mdu, input logic hilo);
        id_valid = v; id_src1_en = s1e; id_src1 = s1; id_src2_en = s2e; id_src2 = s2;
        id_dst_en = de; id_dst = d; id_is_load = ld; id_is_mdu = mdu; id_uses_hilo = hilo;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0;
    endtask

    task automatic advance();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 0 || fwd_sel2 !== 0 || mdu_busy !== 0 || stall_count !== 0) begin
            errors++; $display("FAIL reset_idle: stall=%0b sel1=%0d sel2=%0d busy=%0b cnt=%0d, want all 0", stall, fwd_sel1, fwd_sel2, mdu_busy, stall_count); end
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // mult
        advance();
        drive(1, 1, 1, 0, 0, 1, 5, 0, 0, 0);   // add r5
        advance();
        idle();
        @(negedge clk);
        checks++; if (mdu_busy !== 1) begin
            errors++; $display("FAIL reset_pre_busy: mdu_busy=%0b want 1", mdu_busy); end
        rst_n = 0;
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 1);   // mflo-like reader of r5
        #1;
        checks++; if (mdu_busy !== 0 || stall_count !== 0 || stall !== 0 || fwd_sel1 !== 0) begin
            errors++; $display("FAIL reset_async: busy=%0b cnt=%0d stall=%0b sel1=%0d want 0", mdu_busy, stall_count, stall, fwd_sel1); end
        advance();
        rst_n = 1;
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 0 || mdu_busy !== 0 || stall_count !== 0) begin
            errors++; $display("FAIL reset_after: stall=%0b sel1=%0d busy=%0b cnt=%0d want 0", stall, fwd_sel1, mdu_busy, stall_count); end
        advance();
        idle();
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drive(1, 1, 1, 1, 2, 1, 5, 0, 0, 0);   // add r5,r1,r2
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 0 || fwd_sel2 !== 0) begin
            errors++; $display("FAIL alu_first: stall=%0b sel1=%0d sel2=%0d want 0 0 0", stall, fwd_sel1, fwd_sel2); end
        advance();
        drive(1, 1, 5, 1, 5, 1, 6, 0, 0, 0);   // sub r6,r5,r5
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 1 || fwd_sel2 !== 1) begin
            errors++; $display("FAIL alu_dist1: stall=%0b sel1=%0d sel2=%0d want 0 1 1", stall, fwd_sel1, fwd_sel2); end
        advance();
        drive(1, 1, 5, 1, 7, 0, 0, 0, 0, 0);   // reads r5, r7
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 2 || fwd_sel2 !== 0) begin
            errors++; $display("FAIL alu_dist2: stall=%0b sel1=%0d sel2=%0d want 0 2 0", stall, fwd_sel1, fwd_sel2); end
        advance();
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (fwd_sel1 !== 3) begin
            errors++; $display("FAIL alu_dist3: sel1=%0d want 3", fwd_sel1); end
        advance();
        drive(1, 1, 5, 1, 6, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (fwd_sel1 !== 0 || fwd_sel2 !== 3 || stall !== 0) begin
            errors++; $display("FAIL alu_dist4: sel1=%0d sel2=%0d stall=%0b want 0 3 0", fwd_sel1, fwd_sel2, stall); end
        advance();
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 1, 1, 0, 0, 1, 8, 1, 0, 0);   // lw r8
        advance();
        drive(1, 1, 8, 1, 1, 1, 9, 0, 0, 0);   // add r9,r8,r1
        @(negedge clk);
        checks++; if (stall !== 1 || fwd_sel1 !== 0 || fwd_sel2 !== 0) begin
            errors++; $display("FAIL load_use_stall: stall=%0b sel1=%0d sel2=%0d want 1 0 0", stall, fwd_sel1, fwd_sel2); end
        advance();
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 2 || stall_count !== 1) begin
            errors++; $display("FAIL load_use_go: stall=%0b sel1=%0d cnt=%0d want 0 2 1", stall, fwd_sel1, stall_count); end
        advance();
        idle();
        advance();
        checks++; if (stall_count !== 1) begin
            errors++; $display("FAIL load_use_cnt: cnt=%0d want 1", stall_count); end
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1, 1, 1, 0, 0, 1, 3, 0, 0, 0);   // add r3
        advance();
        drive(1, 1, 2, 0, 0, 1, 3, 0, 0, 0);   // add r3
        advance();
        drive(1, 1, 3, 1, 0, 1, 4, 0, 0, 0);   // or r4,r3,r0
        @(negedge clk);
        checks++; if (fwd_sel1 !== 1 || fwd_sel2 !== 0 || stall !== 0) begin
            errors++; $display("FAIL youngest: sel1=%0d sel2=%0d stall=%0b want 1 0 0", fwd_sel1, fwd_sel2, stall); end
        advance();
        drive(1, 1, 1, 0, 0, 1, 0, 1, 0, 0);   // lw r0
        advance();
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);   // reads r0, r0
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 0 || fwd_sel2 !== 0) begin
            errors++; $display("FAIL r0_never: stall=%0b sel1=%0d sel2=%0d want 0 0 0", stall, fwd_sel1, fwd_sel2); end
        advance();
        idle();
    endtask

    task automatic test_mdu();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // mult
        advance();
        drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);   // mflo r2
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (stall !== 1 || mdu_busy !== 1) begin
                errors++; $display("FAIL mdu_stall_c%0d: stall=%0b busy=%0b want 1 1", i, stall, mdu_busy); end
            advance();
        end
        @(negedge clk);
        checks++; if (stall !== 0 || mdu_busy !== 0 || stall_count !== 4) begin
            errors++; $display("FAIL mdu_release: stall=%0b busy=%0b cnt=%0d want 0 0 4", stall, mdu_busy, stall_count); end
        advance();
        // Second mult arriving on the cycle the counter reads 1.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        advance();
        idle();
        repeat (3) advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (stall !== 1 || mdu_busy !== 1) begin
            errors++; $display("FAIL mdu_back_to_back: stall=%0b busy=%0b want 1 1", stall, mdu_busy); end
        advance();
        @(negedge clk);
        checks++; if (stall !== 0 || mdu_busy !== 0) begin
            errors++; $display("FAIL mdu_second_issue: stall=%0b busy=%0b want 0 0", stall, mdu_busy); end
        advance();
        idle();
        @(negedge clk);
        checks++; if (mdu_busy !== 1) begin
            errors++; $display("FAIL mdu_reload: busy=%0b want 1", mdu_busy); end
        advance();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 1, 0, 0, 1, 8, 1, 0, 0);   // lw r8
        advance();
        drive(1, 1, 8, 0, 0, 1, 9, 0, 0, 0);   // add r9,r8 squashed
        flush = 1;
        @(negedge clk);
        checks++; if (stall !== 0) begin
            errors++; $display("FAIL flush_stall: stall=%0b want 0", stall); end
        advance();
        flush = 0;
        drive(1, 1, 9, 1, 8, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (stall !== 0 || fwd_sel1 !== 0 || fwd_sel2 !== 2 || stall_count !== 0) begin
            errors++; $display("FAIL flush_bubble: stall=%0b sel1=%0d sel2=%0d cnt=%0d want 0 0 2 0", stall, fwd_sel1, fwd_sel2, stall_count); end
        advance();
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        // A continuous stream of mults stalls 4 of every 5 cycles.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (5) advance();
        checks++; if (stall_count !== 4) begin
            errors++; $display("FAIL sat_partial: cnt=%0d want 4", stall_count); end
        repeat (20) advance();   // 20 stall cycles so far
        checks++; if (stall_count !== 15) begin
            errors++; $display("FAIL sat_20: cnt=%0d want 15", stall_count); end
        repeat (5) advance();    // 24 stalls: a wrapping counter would read 8
        checks++; if (stall_count !== 15) begin
            errors++; $display("FAIL sat_hold: cnt=%0d want 15", stall_count); end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_mdu();
        test_flush();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
